// File: rtl/pwr_gated_logic_array.sv
// WIDTH-channel registered two-input logic stage, clamped to zero by a
// keep-alive power sequencer (OFF -> SETTLE -> ON) with a brown-out counter.
module pwr_gated_logic_array #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kapwr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             pwr_ok,
  output logic [7:0]       brownout_cnt
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2
  } state_e;

  localparam logic [7:0] SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

  // in_valid has no ready: a sample is consumed only at an edge where the
  // state is ON and kapwr_s is still 1; anything else is silently dropped.
  state_e           state_q, state_d;
  logic             ka_meta_q, ka_meta_d;
  logic             kapwr_s_q, kapwr_s_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             pwr_ok_q, pwr_ok_d;
  logic [7:0]       bo_q, bo_d;
  logic             bo_inc;
  logic [WIDTH-1:0] f_val;

  always_comb begin
    case (mode)
      2'b00:   f_val = ~(a & b);
      2'b01:   f_val = a & b;
      2'b10:   f_val = ~(a | b);
      default: f_val = a | b;
    endcase
  end

  always_comb begin
    ka_meta_d   = kapwr;
    kapwr_s_d   = ka_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    bo_inc      = 1'b0;
    case (state_q)
      ST_OFF: begin
        y_d   = '0;
        cnt_d = 8'd0;
        if (kapwr_s_q) state_d = (SETTLE == 0) ? ST_ON : ST_SETTLE;
      end
      ST_SETTLE: begin
        y_d = '0;
        if (!kapwr_s_q) begin
          state_d = ST_OFF;
          cnt_d   = 8'd0;
          bo_inc  = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ON;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ON: begin
        // Power loss wins over a simultaneous valid input.
        if (!kapwr_s_q) begin
          state_d = ST_OFF;
          y_d     = '0;
          bo_inc  = 1'b1;
        end else if (in_valid) begin
          y_d         = f_val;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        y_d     = '0;
        cnt_d   = 8'd0;
      end
    endcase
    bo_d = bo_q;
    if (bo_inc && (bo_q != 8'hFF)) bo_d = bo_q + 8'd1;
    pwr_ok_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ka_meta_q   <= 1'b0;
      kapwr_s_q   <= 1'b0;
      state_q     <= ST_OFF;
      cnt_q       <= 8'd0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      pwr_ok_q    <= 1'b0;
      bo_q        <= 8'd0;
    end else begin
      ka_meta_q   <= ka_meta_d;
      kapwr_s_q   <= kapwr_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      pwr_ok_q    <= pwr_ok_d;
      bo_q        <= bo_d;
    end
  end

  assign y            = y_q;
  assign out_valid    = out_valid_q;
  assign pwr_ok       = pwr_ok_q;
  assign brownout_cnt = bo_q;

endmodule

// File: tb/tb_pwr_gated_logic_array.sv
// Directed bench: two instances (SETTLE=4 and SETTLE=0) sharing clock, reset and data inputs.
module tb_pwr_gated_logic_array;

  logic       clk;
  logic       rst;
  logic       kapwr;
  logic       kapwr0;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] mode;
  logic       in_valid;
  logic [7:0] y;
  logic       out_valid;
  logic       pwr_ok;
  logic [7:0] brownout_cnt;
  logic [7:0] y0;
  logic       out_valid0;
  logic       pwr_ok0;
  logic [7:0] brownout_cnt0;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_bo = 8'd0;

  pwr_gated_logic_array #(.WIDTH(8), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .kapwr(kapwr), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .y(y), .out_valid(out_valid), .pwr_ok(pwr_ok),
    .brownout_cnt(brownout_cnt)
  );

  pwr_gated_logic_array #(.WIDTH(8), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .kapwr(kapwr0), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .y(y0), .out_valid(out_valid0), .pwr_ok(pwr_ok0),
    .brownout_cnt(brownout_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_init();
    rst = 1'b1; kapwr = 1'b0; kapwr0 = 1'b0;
    a = 8'h00; b = 8'h00; mode = 2'b00; in_valid = 1'b0;
    tick(); tick();
    tests_run++;
    if ({y, out_valid, pwr_ok, brownout_cnt} !== 18'd0) begin
      fails++;
      $display("FAIL init_reset: got y=%h ov=%b ok=%b bo=%0d, want all 0", y, out_valid, pwr_ok, brownout_cnt);
    end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_power_up();
    a = 8'hF0; b = 8'hCC; mode = 2'b01; in_valid = 1'b1;
    kapwr = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      tests_run++;
      if (pwr_ok !== (e == 6)) begin
        fails++;
        $display("FAIL pwr_up_ok edge %0d: got %b want %b", e, pwr_ok, (e == 6));
      end
      tests_run++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL pwr_up_drop edge %0d: out_valid got %b want 0", e, out_valid);
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || y !== 8'hC0) begin
      fails++;
      $display("FAIL pwr_up_first: got y=%h ov=%b want y=c0 ov=1", y, out_valid);
    end
  endtask

  task automatic test_functions();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'h3F; exp_tab[1] = 8'hC0; exp_tab[2] = 8'h03; exp_tab[3] = 8'hFC;
    a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      tick();
      tests_run++;
      if (y !== exp_tab[m] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL func mode %0d: got y=%h ov=%b want y=%h ov=1", m, y, out_valid, exp_tab[m]);
      end
    end
  endtask

  task automatic test_back_to_back();
    a = 8'hAA; b = 8'h0F; mode = 2'b11; in_valid = 1'b1;
    tick();
    tests_run++;
    if (y !== 8'hAF || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_or: got y=%h ov=%b want af/1", y, out_valid);
    end
    a = 8'h33; b = 8'h55; mode = 2'b00;
    tick();
    tests_run++;
    if (y !== 8'hEE || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_nand: got y=%h ov=%b want ee/1", y, out_valid);
    end
    a = 8'h00; b = 8'h00; in_valid = 1'b0;
    tick();
    tests_run++;
    if (y !== 8'hEE || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_hold: got y=%h ov=%b want ee/0", y, out_valid);
    end
    a = 8'hFF; b = 8'h81; mode = 2'b01; in_valid = 1'b1;
    tick();
    tests_run++;
    if (y !== 8'h81 || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_and: got y=%h ov=%b want 81/1", y, out_valid);
    end
    a = 8'h0F; b = 8'h30; mode = 2'b10;
    tick();
    tests_run++;
    if (y !== 8'hC0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_nor: got y=%h ov=%b want c0/1", y, out_valid);
    end
  endtask

  task automatic test_brownout();
    a = 8'h12; b = 8'h40; mode = 2'b11; in_valid = 1'b1;
    kapwr = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      tests_run++;
      if (y !== 8'h52 || out_valid !== 1'b1 || pwr_ok !== 1'b1) begin
        fails++; $display("FAIL bo_before edge %0d: got y=%h ov=%b ok=%b want 52/1/1", e, y, out_valid, pwr_ok);
      end
    end
    tick();
    exp_bo = exp_bo + 8'd1;
    tests_run++;
    if (y !== 8'h00 || out_valid !== 1'b0 || pwr_ok !== 1'b0 || brownout_cnt !== exp_bo) begin
      fails++; $display("FAIL bo_clamp: got y=%h ov=%b ok=%b bo=%0d want 00/0/0/%0d", y, out_valid, pwr_ok, brownout_cnt, exp_bo);
    end
    tick();
    tests_run++;
    if (y !== 8'h00 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bo_off: got y=%h ov=%b want 00/0", y, out_valid);
    end
    kapwr = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      tests_run++;
      if (pwr_ok !== (e == 6) || out_valid !== 1'b0) begin
        fails++; $display("FAIL bo_resettle edge %0d: got ok=%b ov=%b want %b/0", e, pwr_ok, out_valid, (e == 6));
      end
    end
    tick();
    tests_run++;
    if (y !== 8'h52 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bo_resume: got y=%h ov=%b want 52/1", y, out_valid);
    end
  endtask

  task automatic test_settle_glitch();
    in_valid = 1'b0;
    kapwr = 1'b0;
    tick(); tick(); tick();
    exp_bo = exp_bo + 8'd1;
    tests_run++;
    if (brownout_cnt !== exp_bo || pwr_ok !== 1'b0) begin
      fails++; $display("FAIL glitch_off: got bo=%0d ok=%b want %0d/0", brownout_cnt, pwr_ok, exp_bo);
    end
    tick(); tick();
    // kapwr high before edges r..r+2, low before r+3..r+5: drop seen with counter at 2.
    kapwr = 1'b1;
    tick(); tick(); tick();
    kapwr = 1'b0;
    tick(); tick();
    tests_run++;
    if (brownout_cnt !== exp_bo) begin
      fails++; $display("FAIL glitch_pre: got bo=%0d want %0d", brownout_cnt, exp_bo);
    end
    tick();
    exp_bo = exp_bo + 8'd1;
    tests_run++;
    if (brownout_cnt !== exp_bo || pwr_ok !== 1'b0) begin
      fails++; $display("FAIL glitch_loss: got bo=%0d ok=%b want %0d/0", brownout_cnt, pwr_ok, exp_bo);
    end
    kapwr = 1'b1;
    for (int e = 6; e <= 12; e++) begin
      tick();
      tests_run++;
      if (pwr_ok !== (e == 12)) begin
        fails++; $display("FAIL glitch_resettle edge r+%0d: got ok=%b want %b", e, pwr_ok, (e == 12));
      end
    end
  endtask

  task automatic test_reset();
    a = 8'hA5; b = 8'h00; mode = 2'b11; in_valid = 1'b1;
    tick();
    tests_run++;
    if (y !== 8'hA5 || out_valid !== 1'b1 || brownout_cnt !== exp_bo) begin
      fails++; $display("FAIL rst_pre: got y=%h ov=%b bo=%0d want a5/1/%0d", y, out_valid, brownout_cnt, exp_bo);
    end
    #2;
    rst = 1'b1;
    kapwr = 1'b0;
    #1;
    tests_run++;
    if (y !== 8'h00 || out_valid !== 1'b0 || pwr_ok !== 1'b0 || brownout_cnt !== 8'd0) begin
      fails++; $display("FAIL rst_async: got y=%h ov=%b ok=%b bo=%0d want 00/0/0/0", y, out_valid, pwr_ok, brownout_cnt);
    end
    tick();
    rst = 1'b0;
    exp_bo = 8'd0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pwr_ok !== 1'b0 || y !== 8'h00) begin
      fails++; $display("FAIL rst_release: got y=%h ov=%b ok=%b want 00/0/0", y, out_valid, pwr_ok);
    end
  endtask

  task automatic test_saturation();
    in_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      kapwr = 1'b1;
      tick(); tick(); tick();
      kapwr = 1'b0;
      tick(); tick(); tick();
      if (exp_bo != 8'hFF) exp_bo = exp_bo + 8'd1;
      if (i == 10 || i == 255 || i == 300) begin
        tests_run++;
        if (brownout_cnt !== exp_bo) begin
          fails++; $display("FAIL sat event %0d: got bo=%0d want %0d", i, brownout_cnt, exp_bo);
        end
      end
    end
  endtask

  task automatic test_settle0();
    a = 8'hF0; b = 8'hCC; mode = 2'b01; in_valid = 1'b1;
    kapwr0 = 1'b1;
    for (int e = 0; e <= 2; e++) begin
      tick();
      tests_run++;
      if (pwr_ok0 !== (e == 2) || out_valid0 !== 1'b0) begin
        fails++; $display("FAIL s0_up edge %0d: got ok=%b ov=%b want %b/0", e, pwr_ok0, out_valid0, (e == 2));
      end
    end
    tick();
    tests_run++;
    if (y0 !== 8'hC0 || out_valid0 !== 1'b1 || brownout_cnt0 !== 8'd0) begin
      fails++; $display("FAIL s0_data: got y=%h ov=%b bo=%0d want c0/1/0", y0, out_valid0, brownout_cnt0);
    end
  endtask

  initial begin
    test_init();
    test_power_up();
    test_functions();
    test_back_to_back();
    test_brownout();
    test_settle_glitch();
    test_reset();
    test_saturation();
    test_settle0();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/pwr_gated_logic_array.md
# pwr_gated_logic_array

Parametrised, registered successor to the single keep-alive-gated NAND cell. It processes WIDTH independent bit channels with a selectable two-input function and registers the result. A power-sequencing state machine clamps the outputs to 0 while keep-alive power is absent and for a programmable settle window after it returns. It also counts brown-out events. The block sits between always-on control logic and switchable-domain consumers, as the isolation/evaluation stage.

## Interface
Parameters:
- WIDTH, 8: number of bit channels (≥1).
- SETTLE, 4: cycles kapwr must stay good before outputs are released (0..255; 0 releases immediately).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset; asynchronous, active-high.
- kapwr, input, 1: keep-alive power-good level; asynchronous to clk.
- a, input, WIDTH: operand A, one bit per channel.
- b, input, WIDTH: operand B, one bit per channel.
- mode, input, 2: function select; 00 NAND, 01 AND, 10 NOR, 11 OR.
- in_valid, input, 1: a/b/mode are valid this cycle.
- y, output, WIDTH: registered, clamped result.
- out_valid, output, 1: y carries a new result this cycle.
- pwr_ok, output, 1: high only in state ON.
- brownout_cnt, output, 8: saturating count of power losses from SETTLE or ON.

## Operation
- kapwr passes through a 2-flop synchroniser to kapwr_s; both flops reset to 0. Nothing else uses kapwr directly.
- State OFF (reset state):
  - y=0, out_valid=0.
  - kapwr_s=1 moves to SETTLE with settle counter cleared, or directly to ON if SETTLE=0.
- State SETTLE:
  - Outputs stay clamped (y=0, out_valid=0).
  - The counter increments each cycle kapwr_s=1. When the counter equals SETTLE-1 at an edge, the state moves to ON.
  - kapwr_s=0 moves to OFF, clears the counter and increments brownout_cnt.
- State ON:
  - When in_valid=1, y <= f(a,b,mode) bitwise per channel and out_valid <= 1.
  - When in_valid=0, y holds its value and out_valid <= 0.
  - kapwr_s=0 moves to OFF. On that same edge y <= 0 and out_valid <= 0 regardless of in_valid, and brownout_cnt increments.
- brownout_cnt saturates at 255 and clears only on rst.
- State encoding is internal; the only permitted state values are OFF, SETTLE and ON. Any illegal state recovers to OFF on the next edge.
- All channels share mode and in_valid; there is no per-channel state.

## Timing
- Reset values: y=0, out_valid=0, pwr_ok=0, brownout_cnt=0, state OFF, synchroniser 0, counter 0.
- Reset takes effect immediately (asynchronously). After deassertion the block restarts from OFF; no result in flight survives.
- Power-up latency: if kapwr goes high before edge n and stays high, kapwr_s is 1 after edge n+1.
  - The state is SETTLE after edge n+2 and ON after edge n+2+SETTLE.
  - pwr_ok goes high with ON.
  - With SETTLE=0, the state is ON after edge n+2.
- Data latency in ON: inputs sampled at edge m appear on y/out_valid after edge m; 1 cycle, fully pipelined, one result per cycle.
- in_valid sampled at the edge that leaves ON, or in any non-ON state, is dropped; no result is produced for it.
- Power-loss latency: if kapwr drops before edge n, y is 0 after edge n+2 and brownout_cnt updates at that same edge.
- A kapwr glitch shorter than one cycle may be missed; this is legal. Any drop seen by kapwr_s during SETTLE restarts the full window.
- Simultaneous events: rst dominates everything. A power loss dominates in_valid.

## Test plan
- Reset: assert rst mid-stream with y=8'hA5 -> y=0, out_valid=0, pwr_ok=0 and brownout_cnt=0 immediately, with no clock edge needed.
- Power-up, SETTLE=4: raise kapwr before edge 0 -> pwr_ok=1 first after edge 6. in_valid presented earlier produces no out_valid.
- Functions, WIDTH=8: a=8'hF0, b=8'hCC, in_valid=1 in ON -> the next cycle gives y=8'h3F for NAND, 8'hC0 for AND, 8'h03 for NOR, 8'hFC for OR, each with out_valid=1.
- Brown-out mid-stream: continuous in_valid in ON, drop kapwr -> y=0 and out_valid=0 two edges later, brownout_cnt=1. Restoring kapwr needs a full SETTLE window again.
- Settle glitch: kapwr low for 3 cycles while counter=2 in SETTLE -> OFF, brownout_cnt+1, counter restarts from 0, ON reached SETTLE+2 edges after kapwr returns.
- Saturation and SETTLE=0: 300 power-loss events give brownout_cnt=255. With SETTLE=0, ON is reached 2 edges after kapwr rises.
